// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types, legal parameter ranges and parity helper for the
//            UART receiver.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  localparam int c_DATA_BITS_MIN  = 5;
  localparam int c_DATA_BITS_MAX  = 9;
  localparam int c_OVERSAMPLE_MIN = 8;
  localparam int c_OVERSAMPLE_MAX = 32;
  localparam int c_PARITY_W       = c_DATA_BITS_MAX + 1;

  // Nonzero means the data bits plus received parity bit break the parity rule.
  function automatic logic uart_parity_err(input logic [c_PARITY_W-1:0] bits,
                                           input logic                  odd);
    return (^bits) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param_if
// Brief    : Received-word valid/ready handshake with per-word error flags.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchroniser with a configurable reset value.
// Revision : 1.0  initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire  clk,
  input  wire  arst_n,
  input  wire  i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with majority voting,
//            parity/framing/overrun reporting and a valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  wire              clk,
  input  wire              arst_n,
  input  wire              tick,
  input  wire              rx,
  output logic             busy,
  uart_rx_param_if.master  rx_if
);
  localparam bit c_PARAMS_OK = (DATA_BITS >= c_DATA_BITS_MIN) && (DATA_BITS <= c_DATA_BITS_MAX)
                            && (OVERSAMPLE >= c_OVERSAMPLE_MIN) && (OVERSAMPLE <= c_OVERSAMPLE_MAX)
                            && (OVERSAMPLE % 2 == 0) && (STOP_BITS == 1 || STOP_BITS == 2);

  if (!c_PARAMS_OK) begin : g_param_check
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam int              c_CW        = $clog2(OVERSAMPLE);
  localparam logic [c_CW-1:0] c_SAMPLE0   = c_CW'(OVERSAMPLE/2 - 2);
  localparam logic [c_CW-1:0] c_SAMPLE1   = c_CW'(OVERSAMPLE/2 - 1);
  localparam logic [c_CW-1:0] c_DECIDE    = c_CW'(OVERSAMPLE/2);
  localparam logic [c_CW-1:0] c_LAST      = c_CW'(OVERSAMPLE - 1);
  localparam logic [3:0]      c_LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic            c_LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] c_IDLE      = S_IDLE;
  localparam logic [2:0] c_START     = S_START;
  localparam logic [2:0] c_DATA      = S_DATA;
  localparam logic [2:0] c_PARITY    = S_PARITY;
  localparam logic [2:0] c_STOP      = S_STOP;
  localparam logic [2:0] c_WAIT_HIGH = S_WAIT_HIGH;

  logic                 w_rxs;
  logic [2:0]           r_state;
  logic [c_CW-1:0]      r_cnt;
  logic                 r_s0, r_s1;
  logic [3:0]           r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_perr_o, r_ferr_o, r_ovr;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .i_d    (rx),
    .o_q    (w_rxs)
  );

  wire w_wrap   = tick && (r_cnt == c_LAST);
  wire w_decide = tick && (r_cnt == c_DECIDE);
  wire w_maj    = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  wire w_done   = (r_state == c_STOP) && w_decide && (r_stop == c_LAST_STOP);
  wire w_pbad   = uart_parity_err(c_PARITY_W'({r_shift, w_maj}), PARITY_ODD != 0);

  // The counter parks at 0 in IDLE so the start bit is timed from its edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                 r_cnt <= '0;
    else if (r_state == c_IDLE)  r_cnt <= '0;
    else if (tick)               r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (tick) begin
      if (r_cnt == c_SAMPLE0) r_s0 <= w_rxs;
      if (r_cnt == c_SAMPLE1) r_s1 <= w_rxs;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= c_IDLE;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: if (!w_rxs) begin
          r_state <= c_START;
          r_bit   <= '0;
          r_stop  <= 1'b0;
          r_perr  <= 1'b0;
          r_ferr  <= 1'b0;
        end
        c_START: begin
          if (w_decide && w_maj) r_state <= c_IDLE;
          else if (w_wrap)       r_state <= c_DATA;
        end
        c_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            if (r_bit == c_LAST_BIT) begin
              r_bit   <= '0;
              r_state <= (PARITY_EN != 0) ? c_PARITY : c_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        c_PARITY: begin
          if (w_decide && w_pbad) r_perr  <= 1'b1;
          if (w_wrap)             r_state <= c_STOP;
        end
        c_STOP: begin
          if (w_decide && !w_maj) r_ferr <= 1'b1;
          if (w_done)             r_state <= w_rxs ? c_IDLE : c_WAIT_HIGH;
          else if (w_wrap)        r_stop <= r_stop + 1'b1;
        end
        c_WAIT_HIGH: if (w_rxs) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // A held word wins over a new one unless it is being accepted this cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data   <= r_shift;
          r_perr_o <= r_perr;
          r_ferr_o <= r_ferr | ~w_maj;
          r_valid  <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy              = (r_state != c_IDLE);
  assign rx_if.rx_data     = r_data;
  assign rx_if.rx_valid    = r_valid;
  assign rx_if.parity_err  = r_perr_o;
  assign rx_if.frame_err   = r_ferr_o;
  assign rx_if.overrun_err = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Frame-level model bench for uart_rx_param in 8N1, 8E1 and 8N2.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;
  localparam int c_BIT = 64;   // clocks per bit: 16 ticks, one tick per 4 clocks

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n;
  logic tick;
  logic rx_l [3];
  logic rdy  [3];

  logic [7:0] d_data [3];
  logic       d_valid [3], d_perr [3], d_ferr [3], d_ovr [3], d_busy [3];

  exp_t       expq [3][$];
  int         exp_ovr [3], ovr_seen [3], vcyc [3];
  logic [7:0] last_data [3];
  logic       last_perr [3], last_ferr [3];
  int         n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx_l[0]), .busy(d_busy[0]), .rx_if(if0));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx_l[1]), .busy(d_busy[1]), .rx_if(if1));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx_l[2]), .busy(d_busy[2]), .rx_if(if2));

  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];
  assign if2.rx_ready = rdy[2];
  assign d_data[0] = if0.rx_data;  assign d_valid[0] = if0.rx_valid;  assign d_perr[0] = if0.parity_err;
  assign d_ferr[0] = if0.frame_err; assign d_ovr[0] = if0.overrun_err;
  assign d_data[1] = if1.rx_data;  assign d_valid[1] = if1.rx_valid;  assign d_perr[1] = if1.parity_err;
  assign d_ferr[1] = if1.frame_err; assign d_ovr[1] = if1.overrun_err;
  assign d_data[2] = if2.rx_data;  assign d_valid[2] = if2.rx_valid;  assign d_perr[2] = if2.parity_err;
  assign d_ferr[2] = if2.frame_err; assign d_ovr[2] = if2.overrun_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick = 1'b0;
    forever begin
      wait_clks(3);
      tick = 1'b1;
      wait_clks(1);
      tick = 1'b0;
    end
  end

  // Frame model: the expected word is decided from the line contents; a word
  // that completes while an earlier one is still held and not accepted is lost.
  task automatic send(input int k, input logic [7:0] d, input bit par, input logic pbit,
                      input int nstop, input logic [1:0] stops, input int gbit);
    exp_t e;
    rx_l[k] = 1'b0;
    wait_clks(c_BIT);
    for (int i = 0; i < 8; i++) begin
      rx_l[k] = d[i];
      if (i == gbit) begin
        wait_clks(32);
        rx_l[k] = ~d[i];
        wait_clks(4);
        rx_l[k] = d[i];
        wait_clks(c_BIT - 36);
      end else begin
        wait_clks(c_BIT);
      end
    end
    if (par) begin
      rx_l[k] = pbit;
      wait_clks(c_BIT);
    end
    e.data = d;
    e.perr = par ? ^{d, pbit} : 1'b0;
    e.ferr = 1'b0;
    for (int s = 0; s < nstop; s++) if (!stops[s]) e.ferr = 1'b1;
    if (expq[k].size() != 0 && !rdy[k]) exp_ovr[k]++;
    else                                 expq[k].push_back(e);
    for (int s = 0; s < nstop; s++) begin
      rx_l[k] = stops[s];
      wait_clks(c_BIT);
    end
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (d_valid[k]) begin
          vcyc[k]++;
          if (expq[k].size() == 0) begin
            chk($sformatf("dut%0d_unexpected_valid", k), 32'(d_valid[k]), 32'd0);
          end else begin
            chk($sformatf("dut%0d_data", k), 32'(d_data[k]), 32'(expq[k][0].data));
            chk($sformatf("dut%0d_parity_err", k), 32'(d_perr[k]), 32'(expq[k][0].perr));
            chk($sformatf("dut%0d_frame_err", k), 32'(d_ferr[k]), 32'(expq[k][0].ferr));
            if (rdy[k]) begin
              last_data[k] = d_data[k];
              last_perr[k] = d_perr[k];
              last_ferr[k] = d_ferr[k];
              void'(expq[k].pop_front());
            end
          end
        end
        if (d_ovr[k]) ovr_seen[k]++;
      end
    end
  end

  task automatic chk_reset_vals(input int k, input string tag);
    chk($sformatf("%s_dut%0d_rx_data", tag, k), 32'(d_data[k]), 32'd0);
    chk($sformatf("%s_dut%0d_rx_valid", tag, k), 32'(d_valid[k]), 32'd0);
    chk($sformatf("%s_dut%0d_parity_err", tag, k), 32'(d_perr[k]), 32'd0);
    chk($sformatf("%s_dut%0d_frame_err", tag, k), 32'(d_ferr[k]), 32'd0);
    chk($sformatf("%s_dut%0d_overrun_err", tag, k), 32'(d_ovr[k]), 32'd0);
    chk($sformatf("%s_dut%0d_busy", tag, k), 32'(d_busy[k]), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, o0, guard;
    for (int k = 0; k < 3; k++) begin
      rx_l[k] = 1'b1; rdy[k] = 1'b1;
      exp_ovr[k] = 0; ovr_seen[k] = 0; vcyc[k] = 0;
      last_data[k] = 8'h00; last_perr[k] = 1'b0; last_ferr[k] = 1'b0;
    end
    arst_n = 1'b0;
    wait_clks(5);
    for (int k = 0; k < 3; k++) chk_reset_vals(k, "reset");
    arst_n = 1'b1;
    wait_clks(10);

    // 8N1 0xA5 with ready high: exactly one valid cycle.
    v0 = vcyc[0];
    send(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_clks(20);
    chk("8n1_data", 32'(last_data[0]), 32'h0A5);
    chk("8n1_perr", 32'(last_perr[0]), 32'd0);
    chk("8n1_ferr", 32'(last_ferr[0]), 32'd0);
    chk("8n1_valid_cycles", 32'(vcyc[0] - v0), 32'd1);

    // 8E1: 0x3C carries four ones, so parity bit 1 is wrong; 0x07 with 1 is right.
    send(1, 8'h3C, 1'b1, 1'b1, 1, 2'b11, -1);
    wait_clks(20);
    chk("8e1_bad_data", 32'(last_data[1]), 32'h03C);
    chk("8e1_bad_perr", 32'(last_perr[1]), 32'd1);
    chk("8e1_bad_ferr", 32'(last_ferr[1]), 32'd0);
    send(1, 8'h07, 1'b1, 1'b1, 1, 2'b11, -1);
    wait_clks(20);
    chk("8e1_good_data", 32'(last_data[1]), 32'h007);
    chk("8e1_good_perr", 32'(last_perr[1]), 32'd0);

    // 8N2: clean frame, then 0x81 with second stop low followed by a stuck-low line.
    send(2, 8'h5A, 1'b0, 1'b0, 2, 2'b11, -1);
    wait_clks(20);
    chk("8n2_good_data", 32'(last_data[2]), 32'h05A);
    chk("8n2_good_ferr", 32'(last_ferr[2]), 32'd0);
    send(2, 8'h81, 1'b0, 1'b0, 2, 2'b01, -1);
    wait_clks(40 * c_BIT);
    chk("8n2_break_data", 32'(last_data[2]), 32'h081);
    chk("8n2_break_ferr", 32'(last_ferr[2]), 32'd1);
    chk("8n2_break_busy", 32'(d_busy[2]), 32'd1);
    rx_l[2] = 1'b1;
    wait_clks(10);
    chk("8n2_release_busy", 32'(d_busy[2]), 32'd0);

    // Start glitch of three ticks.
    v0 = vcyc[0];
    rx_l[0] = 1'b0;
    wait_clks(10);
    chk("glitch_busy_high", 32'(d_busy[0]), 32'd1);
    wait_clks(2);
    rx_l[0] = 1'b1;
    wait_clks(38);
    chk("glitch_busy_low", 32'(d_busy[0]), 32'd0);
    wait_clks(2 * c_BIT);
    chk("glitch_no_valid", 32'(vcyc[0] - v0), 32'd0);

    // Overrun: second back-to-back word is dropped while the first is held.
    rdy[0] = 1'b0;
    o0 = ovr_seen[0];
    send(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, -1);
    send(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_clks(20);
    chk("ovr_pulses", 32'(ovr_seen[0] - o0), 32'd1);
    chk("ovr_held_valid", 32'(d_valid[0]), 32'd1);
    chk("ovr_held_data", 32'(d_data[0]), 32'h011);
    rdy[0] = 1'b1;
    guard = 0;
    while (expq[0].size() != 0 && guard < 100) begin
      wait_clks(1);
      guard++;
    end
    chk("ovr_accept_timeout", 32'(guard < 100), 32'd1);
    chk("ovr_accepted_data", 32'(last_data[0]), 32'h011);
    wait_clks(5);
    chk("ovr_valid_dropped", 32'(d_valid[0]), 32'd0);

    // Single-tick inversion at mid-bit on data bit 2 of 0x55.
    send(0, 8'h55, 1'b0, 1'b0, 1, 2'b11, 2);
    wait_clks(20);
    chk("majority_data", 32'(last_data[0]), 32'h055);

    // Reset in the middle of DATA, then a clean frame.
    rx_l[0] = 1'b0; wait_clks(c_BIT);
    rx_l[0] = 1'b1; wait_clks(c_BIT);
    rx_l[0] = 1'b0; wait_clks(c_BIT / 2);
    rx_l[0] = 1'b1;
    arst_n = 1'b0;
    wait_clks(3);
    chk_reset_vals(0, "midreset");
    for (int k = 0; k < 3; k++) expq[k].delete();
    arst_n = 1'b1;
    wait_clks(3 * c_BIT);
    chk("midreset_idle", 32'(d_busy[0]), 32'd0);
    send(0, 8'hC3, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_clks(20);
    chk("after_reset_data", 32'(last_data[0]), 32'h0C3);
    chk("after_reset_ferr", 32'(last_ferr[0]), 32'd0);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_words_left", k), 32'(expq[k].size()), 32'd0);
      chk($sformatf("dut%0d_overruns", k), 32'(ovr_seen[k]), 32'(exp_ovr[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
